// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : pc_sequencer_if
//  Purpose  : Bundles the sequencer's control-unit, PC and instruction-memory
//             signals. The slave modport is the sequencer view; the master
//             modport is the view of the surrounding control unit, PC and
//             memory.
//  Revision : 1.0 - initial release
// ============================================================================
interface pc_sequencer_if;
    logic [7:0] Pc_atual;
    logic [7:0] Proximo_pc;
    logic       Mem_req;
    logic       Mem_ack;
    logic       Fetch_valid;
    logic       Exec_done;
    logic       Stall;
    logic       Branch_taken;
    logic [7:0] Branch_offset;
    logic       Jump;
    logic [7:0] Jump_addr;
    logic       Halt;
    logic       Call;
    logic       Ret;
    logic [2:0] Estado;
    logic       Erro;

    modport master (
        output Pc_atual, Mem_ack, Exec_done, Stall, Branch_taken,
               Branch_offset, Jump, Jump_addr, Halt, Call, Ret,
        input  Proximo_pc, Mem_req, Fetch_valid, Estado, Erro
    );

    modport slave (
        input  Pc_atual, Mem_ack, Exec_done, Stall, Branch_taken,
               Branch_offset, Jump, Jump_addr, Halt, Call, Ret,
        output Proximo_pc, Mem_req, Fetch_valid, Estado, Erro
    );
endinterface
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pc_sequencer
//  Purpose  : Control FSM sequencing an 8-bit PC through fetch, execute and
//             update phases, with instruction-memory handshake, fetch timeout
//             and next-PC selection (halt / jump / branch / sequential).
//  Options  : PC_SEQUENCER_CALL_STACK_EN adds a STACK_DEPTH-entry return
//             address stack driven by Call/Ret. Without it Call/Ret are
//             ignored and no stack storage exists.
//  Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter logic [7:0] RESET_VECTOR = 8'h00,
    parameter int         MEM_TIMEOUT  = 15,
    parameter int         STACK_DEPTH  = 4
) (
    input  wire logic     Clock,
    input  wire logic     Reset_n,
    pc_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_EXEC   = 3'd2,
        S_UPDATE = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    // Last counter value before the timeout fires (counter starts at 0).
    localparam logic [7:0] C_TMO_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     r_state, w_state_nxt;
    logic [7:0] r_pc, w_pc_nxt;
    logic       r_req, w_req_nxt;
    logic       r_fv, w_fv_nxt;
    logic       r_erro, w_erro_nxt;
    logic [7:0] r_cnt, w_cnt_nxt;

`ifdef PC_SEQUENCER_CALL_STACK_EN
    localparam int SPW  = $clog2(STACK_DEPTH + 1);
    localparam int IDXW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [SPW-1:0] C_SP_FULL = SPW'(STACK_DEPTH);

    logic [7:0]     r_stack [STACK_DEPTH];
    logic [SPW-1:0] r_sp;
    logic           w_push, w_pop;
    logic [IDXW-1:0] w_top_idx, w_wr_idx;

    assign w_top_idx = IDXW'(r_sp - SPW'(1));
    assign w_wr_idx  = IDXW'(r_sp);
`else
    logic w_unused_call_ret;
    assign w_unused_call_ret = bus.Call | bus.Ret;
`endif

    // State and registered outputs; reset forces everything back at once.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_VECTOR;
            r_req   <= 1'b0;
            r_fv    <= 1'b0;
            r_erro  <= 1'b0;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_req   <= w_req_nxt;
            r_fv    <= w_fv_nxt;
            r_erro  <= w_erro_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

`ifdef PC_SEQUENCER_CALL_STACK_EN
    // Stack pointer moves on accepted pushes/pops only.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n)
            r_sp <= '0;
        else if (w_push)
            r_sp <= r_sp + SPW'(1);
        else if (w_pop)
            r_sp <= r_sp - SPW'(1);
    end

    // Return-address storage needs no reset; the pointer guards it.
    always_ff @(posedge Clock) begin
        if (w_push)
            r_stack[w_wr_idx] <= 8'(bus.Pc_atual + 8'd1);
    end
`endif

    // Next-state and next-output selection; Stall freezes the active phases.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_req_nxt   = r_req;
        w_fv_nxt    = 1'b0;
        w_erro_nxt  = r_erro;
        w_cnt_nxt   = r_cnt;
`ifdef PC_SEQUENCER_CALL_STACK_EN
        w_push      = 1'b0;
        w_pop       = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                // Vector is already on Proximo_pc, so the PC has loaded it
                // by the time the first fetch is issued.
                w_pc_nxt    = RESET_VECTOR;
                w_cnt_nxt   = 8'd0;
                w_req_nxt   = 1'b1;
                w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (!bus.Stall) begin
                    if (bus.Mem_ack) begin
                        w_req_nxt   = 1'b0;
                        w_fv_nxt    = 1'b1;
                        w_cnt_nxt   = 8'd0;
                        w_state_nxt = S_EXEC;
                    end else if (r_cnt == C_TMO_LAST) begin
                        w_req_nxt   = 1'b0;
                        w_erro_nxt  = 1'b1;
                        w_state_nxt = S_HALT;
                    end else begin
                        w_cnt_nxt   = r_cnt + 8'd1;
                    end
                end
            end
            S_EXEC: begin
                if (!bus.Stall && bus.Exec_done)
                    w_state_nxt = S_UPDATE;
            end
            S_UPDATE: begin
                if (!bus.Stall) begin
                    w_state_nxt = S_FETCH;
                    w_req_nxt   = 1'b1;
                    if (bus.Halt) begin
                        w_pc_nxt    = bus.Pc_atual;
                        w_req_nxt   = 1'b0;
                        w_state_nxt = S_HALT;
                    end
`ifdef PC_SEQUENCER_CALL_STACK_EN
                    else if (bus.Call) begin
                        if (r_sp == C_SP_FULL) begin
                            w_erro_nxt  = 1'b1;
                            w_req_nxt   = 1'b0;
                            w_state_nxt = S_HALT;
                        end else begin
                            w_push   = 1'b1;
                            w_pc_nxt = bus.Jump_addr;
                        end
                    end else if (bus.Ret) begin
                        if (r_sp == '0) begin
                            w_erro_nxt  = 1'b1;
                            w_req_nxt   = 1'b0;
                            w_state_nxt = S_HALT;
                        end else begin
                            w_pop    = 1'b1;
                            w_pc_nxt = r_stack[w_top_idx];
                        end
                    end
`endif
                    else if (bus.Jump)
                        w_pc_nxt = bus.Jump_addr;
                    else if (bus.Branch_taken)
                        // 8-bit add of the two's-complement offset equals the
                        // sign-extended add taken modulo 256.
                        w_pc_nxt = bus.Pc_atual + bus.Branch_offset;
                    else
                        w_pc_nxt = bus.Pc_atual + 8'd1;
                end
            end
            S_HALT: begin
                w_req_nxt = 1'b0;
            end
            default: begin
                w_req_nxt   = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.Proximo_pc  = r_pc;
    assign bus.Mem_req     = r_req;
    assign bus.Fetch_valid = r_fv;
    assign bus.Erro        = r_erro;
    assign bus.Estado      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_pc_sequencer
//  Purpose  : Self-checking bench for pc_sequencer. Models the PC register
//             (negedge capture of Proximo_pc) and memory/control unit, and
//             predicts every next PC from the sequencing rules.
//  Options  : PC_SEQUENCER_CALL_STACK_EN enables the call/return scenarios.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    localparam logic [7:0] RV    = 8'h00;
    localparam int         TMO   = 15;
    localparam int         DEPTH = 4;

    logic Clock   = 1'b0;
    logic Reset_n = 1'b0;

    pc_sequencer_if bus ();

    pc_sequencer #(
        .RESET_VECTOR (RV),
        .MEM_TIMEOUT  (TMO),
        .STACK_DEPTH  (DEPTH)
    ) dut (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    always #5 Clock = ~Clock;

    // PC register model: reloads Proximo_pc on every falling edge.
    logic [7:0] pc_reg;
    always @(negedge Clock or negedge Reset_n) begin
        if (!Reset_n) pc_reg <= RV;
        else          pc_reg <= bus.Proximo_pc;
    end
    assign bus.Pc_atual = pc_reg;

    // Fetch_valid pulse counter.
    int fv_cnt = 0;
    always @(negedge Clock) if (bus.Fetch_valid === 1'b1) fv_cnt++;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] m_pc;
    logic [7:0] m_stack [$];

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic clear_inputs();
        bus.Mem_ack = 1'b0;       bus.Exec_done = 1'b0;
        bus.Stall = 1'b0;         bus.Branch_taken = 1'b0;
        bus.Branch_offset = 8'h00; bus.Jump = 1'b0;
        bus.Jump_addr = 8'h00;    bus.Halt = 1'b0;
        bus.Call = 1'b0;          bus.Ret = 1'b0;
    endtask

    // Reference next-PC for the non-stack cases, from the priority rules.
    function automatic logic [7:0] ref_next(input logic [7:0] pc, input bit jump,
                                            input logic [7:0] ja, input bit br,
                                            input logic [7:0] off);
        int t;
        if (jump) return ja;
        if (br) begin
            t = int'(pc) + int'($signed(off));
            return 8'(((t % 256) + 256) % 256);
        end
        return 8'((int'(pc) + 1) % 256);
    endfunction

    // One full instruction: fetch handshake, execute, update; checks inline.
    task automatic run_instr(input int ack_dly, input int fst, input int est,
                             input bit halt, input bit jump, input logic [7:0] ja,
                             input bit br, input logic [7:0] off,
                             input bit call, input bit ret);
        int n;
        logic [7:0] exp_pc;
        logic [2:0] exp_st;
        bit exp_err;
        n = 0;
        while (bus.Mem_req !== 1'b1 && n < 40) begin step(); n++; end
        n_cmp++;
        if (bus.Mem_req !== 1'b1) begin
            n_bad++;
            $display("FAIL req_wait: Mem_req=%b after %0d cycles, required 1", bus.Mem_req, n);
            return;
        end
        n_cmp++;
        if (bus.Estado !== 3'd1) begin
            n_bad++; $display("FAIL fetch_state: Estado=%0d required 1", bus.Estado);
        end
        repeat (ack_dly) step();
        if (fst > 0) begin
            bus.Stall = 1'b1; bus.Mem_ack = 1'b1;
            repeat (fst) step();
            n_cmp++;
            if ({bus.Estado, bus.Mem_req} !== {3'd1, 1'b1}) begin
                n_bad++; $display("FAIL fetch_stall: Estado=%0d Mem_req=%b required 1/1", bus.Estado, bus.Mem_req);
            end
            bus.Stall = 1'b0;
        end
        bus.Mem_ack = 1'b1;
        step();
        bus.Mem_ack = 1'b0;
        n_cmp++;
        if ({bus.Estado, bus.Fetch_valid, bus.Mem_req} !== {3'd2, 1'b1, 1'b0}) begin
            n_bad++; $display("FAIL exec_entry: Estado=%0d Fetch_valid=%b Mem_req=%b required 2/1/0",
                              bus.Estado, bus.Fetch_valid, bus.Mem_req);
        end
        if (est > 0) begin
            bus.Stall = 1'b1; bus.Exec_done = 1'b1;
            repeat (est) step();
            n_cmp++;
            if ({bus.Estado, bus.Proximo_pc, bus.Fetch_valid} !== {3'd2, m_pc, 1'b0}) begin
                n_bad++; $display("FAIL exec_stall: Estado=%0d Proximo_pc=%h Fetch_valid=%b required 2/%h/0",
                                  bus.Estado, bus.Proximo_pc, bus.Fetch_valid, m_pc);
            end
            bus.Stall = 1'b0;
        end
        bus.Exec_done = 1'b1;
        bus.Halt = halt; bus.Jump = jump; bus.Jump_addr = ja;
        bus.Branch_taken = br; bus.Branch_offset = off;
        bus.Call = call; bus.Ret = ret;
        step();
        bus.Exec_done = 1'b0;
        n_cmp++;
        if ({bus.Estado, bus.Proximo_pc, bus.Fetch_valid} !== {3'd3, m_pc, 1'b0}) begin
            n_bad++; $display("FAIL update_entry: Estado=%0d Proximo_pc=%h Fetch_valid=%b required 3/%h/0",
                              bus.Estado, bus.Proximo_pc, bus.Fetch_valid, m_pc);
        end
        exp_st  = 3'd1;
        exp_err = bus.Erro;
        exp_err = 1'b0;
        if (halt) begin
            exp_pc = m_pc; exp_st = 3'd4;
        end
`ifdef PC_SEQUENCER_CALL_STACK_EN
        else if (call) begin
            if (m_stack.size() == DEPTH) begin
                exp_pc = m_pc; exp_st = 3'd4; exp_err = 1'b1;
            end else begin
                m_stack.push_back(m_pc + 8'd1); exp_pc = ja;
            end
        end else if (ret) begin
            if (m_stack.size() == 0) begin
                exp_pc = m_pc; exp_st = 3'd4; exp_err = 1'b1;
            end else begin
                exp_pc = m_stack.pop_back();
            end
        end
`endif
        else exp_pc = ref_next(m_pc, jump, ja, br, off);
        step();
        n_cmp++;
        if ({bus.Proximo_pc, bus.Estado, bus.Erro, bus.Mem_req} !==
            {exp_pc, exp_st, exp_err, (exp_st == 3'd1)}) begin
            n_bad++; $display("FAIL update_result: Proximo_pc=%h Estado=%0d Erro=%b Mem_req=%b required %h/%0d/%b/%b",
                              bus.Proximo_pc, bus.Estado, bus.Erro, bus.Mem_req,
                              exp_pc, exp_st, exp_err, (exp_st == 3'd1));
        end
        clear_inputs();
        m_pc = exp_pc;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        clear_inputs();
        @(negedge Clock);
        n_cmp++;
        if ({bus.Estado, bus.Proximo_pc, bus.Mem_req, bus.Fetch_valid, bus.Erro} !==
            {3'd0, RV, 1'b0, 1'b0, 1'b0}) begin
            n_bad++; $display("FAIL reset_state: Estado=%0d Proximo_pc=%h Mem_req=%b Fetch_valid=%b Erro=%b required 0/%h/0/0/0",
                              bus.Estado, bus.Proximo_pc, bus.Mem_req, bus.Fetch_valid, bus.Erro, RV);
        end
        @(posedge Clock); #1;
        Reset_n = 1'b1;
        m_pc = RV;
        m_stack.delete();
    endtask

    task automatic test_sequential();
        fv_cnt = 0;
        for (int i = 0; i < 4; i++) run_instr(2, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0);
        @(negedge Clock);
        n_cmp++;
        if (fv_cnt !== 4) begin
            n_bad++; $display("FAIL fetch_valid_count: pulses=%0d required 4", fv_cnt);
        end
        n_cmp++;
        if (bus.Proximo_pc !== 8'h04) begin
            n_bad++; $display("FAIL seq_pc: Proximo_pc=%h required 04", bus.Proximo_pc);
        end
    endtask

    task automatic test_branch();
        run_instr(1, 0, 0, 0, 1, 8'h10, 0, 8'h00, 0, 0);
        run_instr(0, 0, 0, 0, 0, 8'h00, 1, 8'hFC, 0, 0);
        n_cmp++;
        if (bus.Proximo_pc !== 8'h0C) begin
            n_bad++; $display("FAIL branch_back: Proximo_pc=%h required 0c", bus.Proximo_pc);
        end
        run_instr(0, 0, 0, 0, 1, 8'hFF, 0, 8'h00, 0, 0);
        run_instr(0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0);
        n_cmp++;
        if (bus.Proximo_pc !== 8'h00) begin
            n_bad++; $display("FAIL pc_wrap: Proximo_pc=%h required 00", bus.Proximo_pc);
        end
        run_instr(0, 0, 0, 0, 1, 8'h80, 1, 8'h05, 0, 0);
        n_cmp++;
        if (bus.Proximo_pc !== 8'h80) begin
            n_bad++; $display("FAIL jump_priority: Proximo_pc=%h required 80", bus.Proximo_pc);
        end
    endtask

    task automatic test_stall();
        run_instr(1, 3, 5, 0, 0, 8'h00, 1, 8'h07, 0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            bit cr;
`ifdef PC_SEQUENCER_CALL_STACK_EN
            cr = 1'b0;
`else
            cr = 1'($urandom_range(0, 1));
`endif
            run_instr($urandom_range(0, 4), $urandom_range(0, 2), $urandom_range(0, 2), 0,
                      1'($urandom_range(0, 3) == 0), 8'($urandom), 1'($urandom_range(0, 1)),
                      8'($urandom), cr, 1'($urandom_range(0, 1)));
        end
    endtask

`ifdef PC_SEQUENCER_CALL_STACK_EN
    task automatic test_call_stack();
        test_reset();
        run_instr(0, 0, 0, 0, 1, 8'h20, 0, 8'h00, 0, 0);
        run_instr(0, 0, 0, 0, 0, 8'h50, 0, 8'h00, 1, 0);
        n_cmp++;
        if (bus.Proximo_pc !== 8'h50) begin
            n_bad++; $display("FAIL call_target: Proximo_pc=%h required 50", bus.Proximo_pc);
        end
        run_instr(0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 1);
        n_cmp++;
        if (bus.Proximo_pc !== 8'h21) begin
            n_bad++; $display("FAIL ret_target: Proximo_pc=%h required 21", bus.Proximo_pc);
        end
        for (int i = 0; i < 5; i++)
            run_instr(0, 0, 0, 0, 0, 8'(8'h60 + i), 0, 8'h00, 1, 0);
        n_cmp++;
        if ({bus.Erro, bus.Estado} !== {1'b1, 3'd4}) begin
            n_bad++; $display("FAIL stack_overflow: Erro=%b Estado=%0d required 1/4", bus.Erro, bus.Estado);
        end
    endtask
`endif

    task automatic test_halt();
        logic [7:0] held;
        run_instr(0, 0, 0, 1, 1, 8'h33, 0, 8'h00, 0, 0);
        held = m_pc;
        bus.Mem_ack = 1'b1; bus.Exec_done = 1'b1;
        repeat (4) step();
        clear_inputs();
        n_cmp++;
        if ({bus.Estado, bus.Mem_req, bus.Proximo_pc} !== {3'd4, 1'b0, held}) begin
            n_bad++; $display("FAIL halt_hold: Estado=%0d Mem_req=%b Proximo_pc=%h required 4/0/%h",
                              bus.Estado, bus.Mem_req, bus.Proximo_pc, held);
        end
    endtask

    task automatic test_timeout();
        test_reset();
        step();
        n_cmp++;
        if ({bus.Estado, bus.Mem_req} !== {3'd1, 1'b1}) begin
            n_bad++; $display("FAIL tmo_start: Estado=%0d Mem_req=%b required 1/1", bus.Estado, bus.Mem_req);
        end
        repeat (TMO - 1) step();
        n_cmp++;
        if ({bus.Estado, bus.Erro} !== {3'd1, 1'b0}) begin
            n_bad++; $display("FAIL tmo_early: Estado=%0d Erro=%b required 1/0", bus.Estado, bus.Erro);
        end
        step();
        n_cmp++;
        if ({bus.Estado, bus.Erro, bus.Mem_req} !== {3'd4, 1'b1, 1'b0}) begin
            n_bad++; $display("FAIL tmo_fire: Estado=%0d Erro=%b Mem_req=%b required 4/1/0",
                              bus.Estado, bus.Erro, bus.Mem_req);
        end
        bus.Mem_ack = 1'b1;
        repeat (3) step();
        bus.Mem_ack = 1'b0;
        n_cmp++;
        if ({bus.Estado, bus.Erro, bus.Mem_req} !== {3'd4, 1'b1, 1'b0}) begin
            n_bad++; $display("FAIL erro_sticky: Estado=%0d Erro=%b Mem_req=%b required 4/1/0",
                              bus.Estado, bus.Erro, bus.Mem_req);
        end
    endtask

    task automatic test_reset_midfetch();
        test_reset();
        run_instr(0, 0, 0, 0, 1, 8'h44, 0, 8'h00, 0, 0);
        step();
        #2 Reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.Estado, bus.Mem_req, bus.Proximo_pc, bus.Fetch_valid, bus.Erro} !==
            {3'd0, 1'b0, RV, 1'b0, 1'b0}) begin
            n_bad++; $display("FAIL async_reset: Estado=%0d Mem_req=%b Proximo_pc=%h Fetch_valid=%b Erro=%b required 0/0/%h/0/0",
                              bus.Estado, bus.Mem_req, bus.Proximo_pc, bus.Fetch_valid, bus.Erro, RV);
        end
        @(posedge Clock); #1;
        Reset_n = 1'b1;
        m_pc = RV;
        m_stack.delete();
        run_instr(1, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        test_reset();
        test_sequential();
        test_branch();
        test_stall();
        test_random();
`ifdef PC_SEQUENCER_CALL_STACK_EN
        test_call_stack();
        test_reset();
`endif
        test_halt();
        test_timeout();
        test_reset_midfetch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Control FSM that sequences the 8-bit PC register through fetch, execute and update phases.
- Drives the PC's `Entrada` input and holds it stable outside the update phase.
- Handles the instruction-memory request/acknowledge handshake and selects the next PC: sequential, branch, jump or halt.
- Sits between the control unit and the PC/instruction memory pair.

Parameters:
- RESET_VECTOR, 8'h00: PC value driven after reset.
- MEM_TIMEOUT, 15: max cycles waiting for Mem_ack before error; range 1..255.
- STACK_DEPTH, 4: return-stack entries; used only with CALL_STACK_EN.

Ports:
- Clock  input  1  system clock; all state updates on posedge.
- Reset_n  input  1  asynchronous, active-low reset.
- Pc_atual  input  8  current PC value, read back from the PC output.
- Proximo_pc  output  8  registered value fed to the PC `Entrada`.
- Mem_req  output  1  instruction fetch request.
- Mem_ack  input  1  instruction memory has data for Pc_atual.
- Fetch_valid  output  1  one-cycle pulse: fetched instruction is valid.
- Exec_done  input  1  control unit finished the current instruction.
- Stall  input  1  freezes the sequencer in its current state.
- Branch_taken  input  1  conditional branch resolved taken.
- Branch_offset  input  8  signed two's-complement offset.
- Jump  input  1  absolute jump request.
- Jump_addr  input  8  absolute jump target.
- Halt  input  1  halt request.
- Call  input  1  call (only with CALL_STACK_EN).
- Ret  input  1  return (only with CALL_STACK_EN).
- Estado  output  3  current FSM state encoding.
- Erro  output  1  sticky error flag.

Behaviour:
- Reset (async, Reset_n=0), effective immediately, including mid-fetch or mid-execute:
  - Proximo_pc=RESET_VECTOR, Mem_req=0, Fetch_valid=0, Erro=0.
  - State=IDLE; timeout counter=0; stack pointer=0.
- State encodings: IDLE=0, FETCH=1, EXEC=2, UPDATE=3, HALT=4.
- IDLE:
  - Proximo_pc=RESET_VECTOR.
  - Next cycle goes to FETCH unconditionally.
  - Needs one extra idle cycle so the PC (negedge capture) loads the vector before the first fetch.
- FETCH:
  - Mem_req=1; timeout counter increments each cycle without Mem_ack.
  - Mem_ack=1 → EXEC; Mem_req drops the same edge; Fetch_valid=1 for exactly the first EXEC cycle; counter cleared.
  - Counter reaches MEM_TIMEOUT with no ack → Erro=1, Mem_req=0 → HALT.
- EXEC:
  - Waits for Exec_done; Exec_done=1 → UPDATE.
  - Exec_done arriving in the same cycle as the Fetch_valid pulse is accepted.
- UPDATE (one cycle), Proximo_pc chosen by priority, registered at the end of the cycle:
  1. Halt → Proximo_pc = Pc_atual, next state HALT.
  2. Jump → Jump_addr.
  3. Branch_taken → Pc_atual + sign-extended Branch_offset, mod 256.
  4. Otherwise → Pc_atual + 1, wrapping 8'hFF→8'h00.
  - Next state FETCH, except when Halt is asserted.
- Proximo_pc is held at its last value in every state except UPDATE and IDLE. The PC therefore reloads the same value on each negedge and is effectively stable.
- HALT:
  - Mem_req=0, outputs frozen.
  - Leaves only via reset; Halt deassertion is ignored.
- Stall=1 in any state except IDLE/HALT:
  - Freezes the state, timeout counter and Proximo_pc.
  - Mem_req is held at its current value.
  - Mem_ack seen during Stall is ignored and must be held by memory.
- Erro is sticky until reset.
- Branch, Jump and Halt are sampled only in UPDATE.

Optional Feature:
- Macro: PC_SEQUENCER_CALL_STACK_EN.
- When defined, adds a STACK_DEPTH-entry return-address stack, checked in UPDATE:
  - Call → push Pc_atual+1 and take Jump_addr; priority below Halt, above Jump.
  - Ret → pop into Proximo_pc; priority below Call.
  - Push when full or pop when empty → Erro=1, → HALT.
- Undefined: Call and Ret ports are present but ignored; no stack storage is synthesized.

Test Plan:
- Reset release, Mem_ack returned 2 cycles after each Mem_req, Exec_done=1 immediately → Proximo_pc sequence 00,01,02,03; one Fetch_valid pulse per instruction.
- Pc_atual=8'h10, Branch_taken=1, Branch_offset=8'hFC in UPDATE → Proximo_pc=8'h0C. Repeat with Pc_atual=8'hFF, no branch → 8'h00.
- Jump=1, Branch_taken=1, Jump_addr=8'h80 together in UPDATE → Proximo_pc=8'h80 (jump wins).
- Mem_ack never asserted, MEM_TIMEOUT=15 → Erro=1 and Estado=4 after 15 FETCH cycles; Mem_req=0 thereafter.
- Stall=1 for 5 cycles mid-EXEC → Estado and Proximo_pc unchanged; resumes on release. Reset_n pulsed low mid-FETCH → outputs immediately at reset values.
- With CALL_STACK_EN: Call at PC 8'h20 to 8'h50, then Ret → Proximo_pc 8'h50 then 8'h21. Five nested calls with STACK_DEPTH=4 → Erro=1, HALT.
